// File: rtl/conv2d_pkg.sv
// Shared types and sizing helpers for the conv2d output serializer.
package conv2d_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   localparam int unsigned FRAME_CNT_W = 16;

   function automatic int unsigned num_elems(input int unsigned batch,
                                             input int unsigned chans,
                                             input int unsigned rows,
                                             input int unsigned cols);
      return batch * chans * rows * cols;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/relu_act.sv
// Combinational ReLU: negative two's complement inputs become zero.
module relu_act #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   assign dout = din[DATA_WIDTH-1] ? '0 : din;

endmodule

// File: rtl/conv2d_out_serializer.sv
// Captures one flattened conv2d output tensor and streams it element by element.
// Define CONV2D_OUT_RELU_EN to apply ReLU on the output path.
module conv2d_out_serializer
   import conv2d_pkg::*;
#(
   parameter  int unsigned BATCH_SIZE   = 1,
   parameter  int unsigned OUT_CHANNELS = 1,
   parameter  int unsigned OUT_HEIGHT   = 2,
   parameter  int unsigned OUT_WIDTH    = 2,
   parameter  int unsigned DATA_WIDTH   = 32,
   localparam int unsigned NUM_ELEMS    = num_elems(BATCH_SIZE, OUT_CHANNELS, OUT_HEIGHT, OUT_WIDTH),
   localparam int unsigned IDX_W        = idx_width(NUM_ELEMS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            tensor_valid,
   output logic                            tensor_ready,
   input  logic [NUM_ELEMS*DATA_WIDTH-1:0] tensor_flat,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [IDX_W-1:0]                out_index,
   output logic                            out_last,
   output logic                            frame_done,
   output logic [FRAME_CNT_W-1:0]          frame_count
);

   state_t                          state_q, state_d;
   logic [NUM_ELEMS*DATA_WIDTH-1:0] buf_q;
   logic [IDX_W-1:0]                idx_q;
   logic [FRAME_CNT_W-1:0]          frame_cnt_q;
   logic                            done_q;
   logic                            capture;
   logic                            accept;
   logic                            is_last;
   logic [DATA_WIDTH-1:0]           elem_raw;
   logic [DATA_WIDTH-1:0]           elem_act;

   assign is_last  = (idx_q == IDX_W'(NUM_ELEMS - 1));
   assign elem_raw = buf_q[32'(idx_q) * DATA_WIDTH +: DATA_WIDTH];

`ifdef CONV2D_OUT_RELU_EN
   relu_act #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_relu_act (
      .din (elem_raw),
      .dout(elem_act)
   );
`else
   assign elem_act = elem_raw;
`endif

   // tensor_ready is gated by rst so it stays low for the whole reset window.
   always_comb begin
      state_d      = state_q;
      tensor_ready = 1'b0;
      out_valid    = 1'b0;
      capture      = 1'b0;
      accept       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tensor_ready = rst;
            capture      = tensor_valid && rst;
            if (capture) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            out_valid = 1'b1;
            accept    = out_ready;
            if (accept && is_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         buf_q       <= '0;
         idx_q       <= '0;
         frame_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= accept && is_last;
         if (capture) begin
            buf_q <= tensor_flat;
            idx_q <= '0;
         end else if (accept && !is_last) begin
            idx_q <= idx_q + 1'b1;
         end
         if (accept && is_last) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
      end
   end

   // Data path outputs are forced to zero outside STREAM so stale buffer contents never leak.
   assign out_data    = out_valid ? elem_act : '0;
   assign out_index   = out_valid ? idx_q : '0;
   assign out_last    = out_valid && is_last;
   assign frame_done  = done_q;
   assign frame_count = frame_cnt_q;

endmodule

// File: doc/conv2d_out_serializer.md
Name: conv2d_out_serializer

Overview:
- Downstream stage of conv2d. Captures one complete flattened output tensor (`output_tensor_flat`) through a valid/ready handshake.
- Streams the tensor out one DATA_WIDTH element per handshake, with index, last-flag and frame bookkeeping.
- Feeds the next stream-based stage: activation, quantizer or entropy-model front end.
- Optional ReLU is applied on the way out.

Parameters:
- BATCH_SIZE, 1, batch count of the captured tensor
- OUT_CHANNELS, 1, channels of the captured tensor
- OUT_HEIGHT, 2, rows per channel
- OUT_WIDTH, 2, columns per row
- DATA_WIDTH, 32, element width, signed two's complement
- Derived localparams: NUM_ELEMS = BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH; IDX_W = max(1, $clog2(NUM_ELEMS)).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- tensor_valid  in  1  tensor_flat holds a complete tensor
- tensor_ready  out  1  block can capture a tensor
- tensor_flat  in  NUM_ELEMS*DATA_WIDTH  flattened tensor; element i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  out_data holds a valid element
- out_ready  in  1  consumer accepts element
- out_data  out  DATA_WIDTH  current element, post-activation
- out_index  out  IDX_W  flat index of current element
- out_last  out  1  current element is index NUM_ELEMS-1
- frame_done  out  1  one-cycle pulse after the last element is accepted
- frame_count  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, capture buffer=0, index=0, frame_count=0. All outputs deassert: out_valid=0, out_data=0, out_index=0, out_last=0, frame_done=0. tensor_ready is 0 while rst=0, then 1 in the first IDLE cycle after release.
- Reset in mid-stream aborts the frame: no frame_done, frame_count unchanged from reset value (0).
- FSM has two states, IDLE and STREAM.
- IDLE:
  - tensor_ready=1, out_valid=0.
  - On tensor_valid&&tensor_ready: register tensor_flat into the buffer, index<=0, go to STREAM.
- STREAM:
  - tensor_ready=0, out_valid=1.
  - out_data = act(buffer[index]); out_index = index; out_last = (index==NUM_ELEMS-1).
  - On out_valid&&out_ready with index<NUM_ELEMS-1: index<=index+1.
  - On out_valid&&out_ready with out_last=1: go to IDLE; frame_done=1 for exactly the next cycle; frame_count<=frame_count+1.
- Latency:
  - First element is valid the cycle after capture.
  - With out_ready held high, one element is emitted per cycle, so a frame takes NUM_ELEMS cycles.
  - There is one IDLE bubble cycle between frames; no capture is overlapped with streaming.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable. The buffer is never modified in STREAM.
- tensor_valid while in STREAM is ignored. It is not queued, and the upstream source must hold it until tensor_ready.
- NUM_ELEMS=1: the single element has out_last=1 immediately.
- Element order follows the flat layout: batch, then channel, then row, then column, column fastest.
- act() is identity unless the optional feature is enabled. Width is preserved throughout; there is no rounding.

Optional Feature:
- Macro: CONV2D_OUT_RELU_EN.
- Defined: act(x) = (x[DATA_WIDTH-1]==1) ? 0 : x, i.e. negative elements are emitted as 0. This is combinational on the output path and adds no latency.
- Undefined: act(x) = x, passing the raw signed value through.

Decomposition:
- Shared package `conv2d_pkg` holds:
  - state encoding constants ST_IDLE=1'b0, ST_STREAM=1'b1
  - NUM_ELEMS/IDX_W computation as a constant function
  - FRAME_CNT_W=16
- One natural sub-module, `relu_act`: DATA_WIDTH-parameterised, combinational, instantiated only under CONV2D_OUT_RELU_EN.
- The FSM, index counter and buffer stay in the top module.

Test Plan:
- Basic frame: capture tensor {164,148,100,84} (elements 3..0, matching conv2d 2x2 output for incremental inputs with unit weights), out_ready=1. Expect out_data 84,100,148,164 on consecutive cycles, out_index 0..3, out_last only on 164, frame_done one cycle later, frame_count=1.
- Backpressure: same tensor, out_ready toggling 1,0,0,1,1,0,1. Expect each element held stable while stalled, no element skipped or duplicated, 4 accepted total.
- Capture guard: assert tensor_valid with a second tensor {1,2,3,4} during STREAM of the first. Expect tensor_ready=0, the first frame unaffected, then the second frame captured in IDLE and emitted as 4,3,2,1. Expect one bubble cycle between frames.
- ReLU: with CONV2D_OUT_RELU_EN, tensor {-5,7,0,-1} (elements 0..3). Expect 0,7,0,0. Without the macro, expect -5,7,0,-1 exactly.
- Reset mid-stream: drop rst after 2 accepted elements. Expect out_valid=0, out_data=0 and frame_count=0 asynchronously, and no frame_done. After release, tensor_ready=1 and the next frame streams from index 0.
- Wrap: force/run 65536 frames (or preload frame_count=0xFFFF via a small NUM_ELEMS config). Expect frame_count=0 after the next frame_done.
